// File: rtl/pool_max_engine.sv
// 2x2 stride-2 signed max pooling over a TILE x TILE register-file tile.
// Ports: clk/nrst, start, rd_addr/rd_en/rd_data (1-cycle read), out_* stream, busy, done.
module pool_max_engine #(
    parameter int DATA_W = 16,
    parameter int TILE   = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int HALF  = TILE / 2;
    localparam int NWIN  = HALF * HALF;
    localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        EMIT,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [1:0]          elem_q, elem_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_en_q, rd_en_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;

    logic                first;
    logic                last_win;
    logic [DATA_W-1:0]   upd;

    // Element e of window w: bit0 steps a column, bit1 steps a row.
    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [WIN_W-1:0] w,
        input logic [1:0]       e
    );
        int r;
        int c;
        int a;
        r = int'(w) / HALF;
        c = int'(w) % HALF;
        a = 2 * r * TILE + 2 * c;
        a = a + (e[1] ? TILE : 0) + (e[0] ? 1 : 0);
        return ADDR_W'(a);
    endfunction

    // rd_data arriving in FETCH with elem_q==1 is element 0 of the window.
    assign first    = (state_q == FETCH) && (elem_q == 2'd1);
    assign last_win = (win_q == WIN_W'(NWIN - 1));
    assign upd      = (first || ($signed(rd_data) > $signed(max_q)))
                      ? rd_data : max_q;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        elem_d      = elem_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = rd_en_q;
        max_d       = max_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    win_d     = '0;
                    elem_d    = 2'd0;
                    rd_addr_d = elem_addr('0, 2'd0);
                    rd_en_d   = 1'b1;
                end
            end
            FETCH: begin
                if (elem_q != 2'd0) begin
                    max_d = upd;
                end
                if (elem_q == 2'd3) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    elem_d    = elem_q + 2'd1;
                    rd_addr_d = elem_addr(win_q, elem_q + 2'd1);
                end
            end
            DRAIN: begin
                max_d       = upd;
                out_data_d  = upd;
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_win) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = FETCH;
                        win_d     = win_q + 1'b1;
                        elem_d    = 2'd0;
                        rd_addr_d = elem_addr(win_q + 1'b1, 2'd0);
                        rd_en_d   = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            win_q       <= '0;
            elem_q      <= 2'd0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            max_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            elem_q      <= elem_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            max_q       <= max_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_en     = rd_en_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/pool_max_engine.md
Name: pool_max_engine

Overview:
- Downstream consumer of the pooling register file.
- Walks a TILE×TILE tile held in the register file through its single registered read port, one address per cycle.
- Computes 2×2 stride-2 signed max pooling and streams (TILE/2)² results out over a valid/ready handshake.
- Sits between the pooling register file and the output/write-back buffer.

Parameters:
- DATA_W, 16, element width (two's-complement signed).
- TILE, 4, tile side length; must be even; TILE*TILE == 2**ADDR_W.
- ADDR_W, 4, register-file address width.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  begin pooling the tile currently in the register file; sampled only in IDLE.
- rd_addr  out  ADDR_W  register-file read address (registered).
- rd_en  out  1  high in cycles where rd_addr carries a live fetch.
- rd_data  in  DATA_W  register-file read data; one-cycle latency, so data for the rd_addr driven in cycle k is valid in cycle k+1.
- out_data  out  DATA_W  pooled maximum.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset (async, nrst=0): state=IDLE; rd_addr=0, rd_en=0, out_data=0, out_valid=0, done=0, busy=0; window and element counters cleared. Reset mid-operation aborts the tile; no partial result is emitted.
- States: IDLE, FETCH, DRAIN, EMIT, FIN.
- IDLE:
  - start=1 → FETCH, window index w=0.
  - start while busy=1 is ignored.
- Window addressing:
  - Window w has row r = w / (TILE/2), col c = w % (TILE/2).
  - base = 2r*TILE + 2c.
  - Element order: base, base+1, base+TILE, base+TILE+1.
  - Windows are visited in raster order; TILE=4 gives bases 0, 2, 8, 10.
- FETCH:
  - 4 cycles; rd_en=1; rd_addr steps through the 4 element addresses.
  - From the second FETCH cycle on, the rd_data returned for the previous address is captured.
  - The first element loads the max register; each later element replaces it only if rd_data > max (signed compare).
  - After the 4th address → DRAIN.
- DRAIN:
  - 1 cycle; rd_en=0; the 4th element is captured and compared.
  - → EMIT.
- EMIT:
  - out_valid=1; out_data = max, held stable while out_ready=0.
  - On out_valid & out_ready: if w is the last window → FIN, else w+1 → FETCH.
  - out_valid drops the cycle after the handshake.
  - No fetch for the next window starts until the handshake completes.
- FIN:
  - done=1 for exactly one cycle; → IDLE (busy=0 in the following cycle).
- Latency:
  - start accepted in cycle 0; addresses in cycles 1–4; DRAIN in cycle 5; out_valid first high in cycle 6.
  - With out_ready held at 1: one result every 6 cycles; done in cycle 25 for TILE=4.
- Arithmetic:
  - Pure signed comparison; no width growth.
  - Ties keep the earlier element; the value is identical either way.
  - Most-negative value (0x8000) is handled correctly.
- Register-file contents must not change while busy=1; the engine does not check this.

Test Plan:
- Registers 0..15 hold values 0..15, start pulse, out_ready=1 → outputs 5, 7, 13, 15 with out_valid in cycles 6, 12, 18, 24; done pulse in cycle 25; rd_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
- Signed data: window 0 holds {0x8000, 0xFFFF, 0xFFFE, 0x8001} → first output 0xFFFF (−1); all-0x8000 tile → four outputs of 0x8000.
- Backpressure: out_ready=0 for 10 cycles after the first out_valid → out_data stays at 5 and rd_en stays 0 throughout; release → handshake completes and the next fetch starts the following cycle.
- start re-pulsed while busy (during FETCH and during EMIT) → ignored; output sequence and timing identical to the first scenario.
- nrst asserted during EMIT of window 1 → out_valid=0, busy=0, rd_en=0 immediately; a new start after reset produces the full 4-result sequence from window 0.
- Back-to-back tiles: start asserted in the cycle after done → accepted and the second tile's results appear with no lost or duplicated outputs.
